// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cpu_pkg
//  Purpose   : Shared definitions for pipeline_cpu. Holds the datapath and
//              memory sizes, the MIPS opcode/funct constants, the ALU-control
//              enum, the pipeline control-bit bundle and the main decoder.
//  Config    : PIPE_MUL_EN - when defined, funct 0x18 decodes as mul;
//              otherwise it decodes as a NOP with no register write.
//  Revision  : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_BYTES = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_MUL = 6'h18;

  // EX operand source selects produced by the forwarding unit
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  // Control bits carried from ID into EX; an all-zero bundle is a NOP
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD};

  // Main decoder: anything not recognised falls through as a NOP.
  // beq and j carry no EX control; they are resolved in ID.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD: begin c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
          FN_SUB: begin c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
          FN_AND: begin c.reg_write = 1'b1; c.alu_op = ALU_AND; end
          FN_OR:  begin c.reg_write = 1'b1; c.alu_op = ALU_OR;  end
`ifdef PIPE_MUL_EN
          FN_MUL: begin c.reg_write = 1'b1; c.alu_op = ALU_MUL; end
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module    : forwarding_unit
//  Purpose   : Combinational operand-forwarding selects. EX operands take
//              EX/MEM first, then MEM/WB; ID branch operands take EX/MEM.
//              Register 0 is never forwarded.
//  Ports     : i_idex_rs/rt      source registers of the instruction in EX
//              i_ifid_rs/rt      source registers of the instruction in ID
//              i_exmem_*         destination and write/load flags in MEM
//              i_memwb_*         destination and write flag in WB
//              o_fwd_a/b         EX operand selects (FWD_REG/EXMEM/MEMWB)
//              o_br_fwd_a/b      1 = branch operand comes from EX/MEM result
//  Config    : none (PIPE_MUL_EN does not affect this block)
//  Revision  : 1.0 - initial release
// ============================================================================
module forwarding_unit
  import cpu_pkg::*;
(
  input  logic [4:0] i_idex_rs,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_exmem_reg_write,
  input  logic       i_exmem_mem_read,
  input  logic [4:0] i_exmem_wreg,
  input  logic       i_memwb_reg_write,
  input  logic [4:0] i_memwb_wreg,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_br_fwd_a,
  output logic       o_br_fwd_b
);

  logic w_exmem_valid;
  logic w_memwb_valid;
  logic w_exmem_alu_valid;

  assign w_exmem_valid = i_exmem_reg_write && (i_exmem_wreg != 5'd0);
  assign w_memwb_valid = i_memwb_reg_write && (i_memwb_wreg != 5'd0);
  // A load in MEM has only its address in the EX/MEM result, so it cannot
  // feed the branch comparator; the hazard logic stalls that case instead.
  assign w_exmem_alu_valid = w_exmem_valid && !i_exmem_mem_read;

  always_comb begin
    o_fwd_a = FWD_REG;
    if (w_exmem_valid && (i_exmem_wreg == i_idex_rs))
      o_fwd_a = FWD_EXMEM;
    else if (w_memwb_valid && (i_memwb_wreg == i_idex_rs))
      o_fwd_a = FWD_MEMWB;

    o_fwd_b = FWD_REG;
    if (w_exmem_valid && (i_exmem_wreg == i_idex_rt))
      o_fwd_b = FWD_EXMEM;
    else if (w_memwb_valid && (i_memwb_wreg == i_idex_rt))
      o_fwd_b = FWD_MEMWB;
  end

  assign o_br_fwd_a = w_exmem_alu_valid && (i_exmem_wreg == i_ifid_rs);
  assign o_br_fwd_b = w_exmem_alu_valid && (i_exmem_wreg == i_ifid_rt);

endmodule
`default_nettype wire

// File: rtl/pipeline_cpu.sv
`default_nettype none
// ============================================================================
//  Module    : pipeline_cpu
//  Purpose   : Five-stage (IF, ID, EX, MEM, WB) in-order MIPS-subset core
//              with instruction/data memories, register file, forwarding,
//              load-use and branch-dependency stalls, and ID-stage branch
//              and jump resolution with a one-slot IF/ID flush.
//  Ports     : clk_i    clock, rising edge
//              start_i  synchronous active-low reset (low = held in reset)
//  Observable: Instruction_Memory.memory, Data_Memory.memory,
//              Registers.register, PC.pc_o,
//              Hazard_Detection_Unit.ID_Flush_lwstall_o (stall), andGate_o
//              (flush)
//  Config    : PIPE_MUL_EN - enables the mul instruction and EX multiplier.
//  Revision  : 1.0 - initial release
// ============================================================================
module pipeline_cpu
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic start_i
);

  // Pipeline registers
  logic [XLEN-1:0] r_ifid_instr, r_ifid_pc4;
  ctrl_t           r_idex_ctrl;
  logic [XLEN-1:0] r_idex_a, r_idex_b, r_idex_imm;
  logic [4:0]      r_idex_rs, r_idex_rt, r_idex_wreg;
  logic            r_exmem_reg_write, r_exmem_mem_to_reg, r_exmem_mem_read, r_exmem_mem_write;
  logic [XLEN-1:0] r_exmem_alu, r_exmem_sdata;
  logic [4:0]      r_exmem_wreg;
  logic            r_memwb_reg_write, r_memwb_mem_to_reg;
  logic [XLEN-1:0] r_memwb_alu, r_memwb_ldata;
  logic [4:0]      r_memwb_wreg;

  // Combinational signals
  logic [XLEN-1:0] w_pc4, w_pc_next, w_fetch;
  logic [5:0]      w_id_op, w_id_fn;
  logic [4:0]      w_id_rs, w_id_rt, w_id_rd, w_id_wreg;
  logic [XLEN-1:0] w_id_imm, w_rs_data, w_rt_data, w_br_a, w_br_b, w_br_target, w_j_target;
  ctrl_t           w_id_ctrl;
  logic            w_is_beq, w_is_j, w_br_taken, w_stall;
  logic [1:0]      w_fwd_a, w_fwd_b;
  logic            w_br_fwd_a, w_br_fwd_b;
  logic [XLEN-1:0] w_op_a, w_fwd_b_val, w_op_b, w_alu;
  logic [XLEN-1:0] w_ld_data, w_wb_data;
  logic            w_wb_we;
  logic            andGate_o;   // IF/ID flush: taken beq or j, unless stalled

  // ---------------------------------------------------------------- IF
  if (1'b1) begin : PC
    logic [XLEN-1:0] pc_o;
    always_ff @(posedge clk_i) begin
      if (!start_i)
        pc_o <= '0;
      else if (!w_stall)
        pc_o <= w_pc_next;
    end
  end

  assign w_pc4     = PC.pc_o + 32'd4;
  assign w_pc_next = andGate_o ? (w_is_j ? w_j_target : w_br_target) : w_pc4;

  if (1'b1) begin : Instruction_Memory
    logic [XLEN-1:0] memory [0:IMEM_WORDS-1];
    assign w_fetch = memory[PC.pc_o[9:2]];
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (!w_stall) begin
      if (andGate_o) begin
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
      end else begin
        r_ifid_instr <= w_fetch;
        r_ifid_pc4   <= w_pc4;
      end
    end
  end

  // ---------------------------------------------------------------- ID
  assign w_id_op   = r_ifid_instr[31:26];
  assign w_id_rs   = r_ifid_instr[25:21];
  assign w_id_rt   = r_ifid_instr[20:16];
  assign w_id_rd   = r_ifid_instr[15:11];
  assign w_id_fn   = r_ifid_instr[5:0];
  assign w_id_imm  = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_id_ctrl = decode(w_id_op, w_id_fn);
  assign w_id_wreg = (w_id_op == OP_RTYPE) ? w_id_rd : w_id_rt;

  assign w_wb_we   = r_memwb_reg_write && (r_memwb_wreg != 5'd0);
  assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_ldata : r_memwb_alu;

  // Write on the rising edge; reads of the register being written this cycle
  // see the new value so WB needs no separate forward into ID.
  if (1'b1) begin : Registers
    logic [XLEN-1:0] register [0:31];
    always_ff @(posedge clk_i) begin
      if (start_i && w_wb_we)
        register[r_memwb_wreg] <= w_wb_data;
    end
    assign w_rs_data = (w_id_rs == 5'd0) ? '0 :
                       (w_wb_we && (r_memwb_wreg == w_id_rs)) ? w_wb_data : register[w_id_rs];
    assign w_rt_data = (w_id_rt == 5'd0) ? '0 :
                       (w_wb_we && (r_memwb_wreg == w_id_rt)) ? w_wb_data : register[w_id_rt];
  end

  assign w_is_beq    = (w_id_op == OP_BEQ);
  assign w_is_j      = (w_id_op == OP_J);
  assign w_br_a      = w_br_fwd_a ? r_exmem_alu : w_rs_data;
  assign w_br_b      = w_br_fwd_b ? r_exmem_alu : w_rt_data;
  assign w_br_taken  = w_is_beq && (w_br_a == w_br_b);
  assign w_br_target = r_ifid_pc4 + {w_id_imm[29:0], 2'b00};
  assign w_j_target  = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
  assign andGate_o   = (w_br_taken || w_is_j) && !w_stall;

  // Stall sources: load-use, beq on a result still in EX, and beq on a load
  // still in MEM (its data does not exist until WB).
  if (1'b1) begin : Hazard_Detection_Unit
    logic ID_Flush_lwstall_o;
    logic w_lw_use, w_br_ex_dep, w_br_mem_dep;
    assign w_lw_use     = r_idex_ctrl.mem_read &&
                          ((r_idex_rt == w_id_rs) || (r_idex_rt == w_id_rt));
    assign w_br_ex_dep  = w_is_beq && r_idex_ctrl.reg_write && (r_idex_wreg != 5'd0) &&
                          ((r_idex_wreg == w_id_rs) || (r_idex_wreg == w_id_rt));
    assign w_br_mem_dep = w_is_beq && r_exmem_mem_read && (r_exmem_wreg != 5'd0) &&
                          ((r_exmem_wreg == w_id_rs) || (r_exmem_wreg == w_id_rt));
    assign ID_Flush_lwstall_o = w_lw_use || w_br_ex_dep || w_br_mem_dep;
  end

  assign w_stall = Hazard_Detection_Unit.ID_Flush_lwstall_o;

  // A stall turns the ID/EX slot into a bubble.
  always_ff @(posedge clk_i) begin
    if (!start_i || w_stall) begin
      r_idex_ctrl <= CTRL_NOP;
      r_idex_a    <= '0;
      r_idex_b    <= '0;
      r_idex_imm  <= '0;
      r_idex_rs   <= '0;
      r_idex_rt   <= '0;
      r_idex_wreg <= '0;
    end else begin
      r_idex_ctrl <= w_id_ctrl;
      r_idex_a    <= w_rs_data;
      r_idex_b    <= w_rt_data;
      r_idex_imm  <= w_id_imm;
      r_idex_rs   <= w_id_rs;
      r_idex_rt   <= w_id_rt;
      r_idex_wreg <= w_id_wreg;
    end
  end

  // ---------------------------------------------------------------- EX
  forwarding_unit u_forwarding_unit (
    .i_idex_rs         (r_idex_rs),
    .i_idex_rt         (r_idex_rt),
    .i_ifid_rs         (w_id_rs),
    .i_ifid_rt         (w_id_rt),
    .i_exmem_reg_write (r_exmem_reg_write),
    .i_exmem_mem_read  (r_exmem_mem_read),
    .i_exmem_wreg      (r_exmem_wreg),
    .i_memwb_reg_write (r_memwb_reg_write),
    .i_memwb_wreg      (r_memwb_wreg),
    .o_fwd_a           (w_fwd_a),
    .o_fwd_b           (w_fwd_b),
    .o_br_fwd_a        (w_br_fwd_a),
    .o_br_fwd_b        (w_br_fwd_b)
  );

  always_comb begin
    case (w_fwd_a)
      FWD_EXMEM: w_op_a = r_exmem_alu;
      FWD_MEMWB: w_op_a = w_wb_data;
      default:   w_op_a = r_idex_a;
    endcase
    case (w_fwd_b)
      FWD_EXMEM: w_fwd_b_val = r_exmem_alu;
      FWD_MEMWB: w_fwd_b_val = w_wb_data;
      default:   w_fwd_b_val = r_idex_b;
    endcase
  end

  assign w_op_b = r_idex_ctrl.alu_src ? r_idex_imm : w_fwd_b_val;

  always_comb begin
    case (r_idex_ctrl.alu_op)
      ALU_SUB: w_alu = w_op_a - w_op_b;
      ALU_AND: w_alu = w_op_a & w_op_b;
      ALU_OR:  w_alu = w_op_a | w_op_b;
`ifdef PIPE_MUL_EN
      ALU_MUL: w_alu = w_op_a * w_op_b;
`endif
      default: w_alu = w_op_a + w_op_b;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_exmem_reg_write  <= 1'b0;
      r_exmem_mem_to_reg <= 1'b0;
      r_exmem_mem_read   <= 1'b0;
      r_exmem_mem_write  <= 1'b0;
      r_exmem_alu        <= '0;
      r_exmem_sdata      <= '0;
      r_exmem_wreg       <= '0;
    end else begin
      r_exmem_reg_write  <= r_idex_ctrl.reg_write;
      r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
      r_exmem_mem_read   <= r_idex_ctrl.mem_read;
      r_exmem_mem_write  <= r_idex_ctrl.mem_write;
      r_exmem_alu        <= w_alu;
      r_exmem_sdata      <= w_fwd_b_val;
      r_exmem_wreg       <= r_idex_wreg;
    end
  end

  // ---------------------------------------------------------------- MEM
  // Little-endian word over a 32-byte array; byte addresses wrap at 32.
  if (1'b1) begin : Data_Memory
    logic [7:0] memory [0:DMEM_BYTES-1];
    logic [4:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = r_exmem_alu[4:0];
    assign w_a1 = w_a0 + 5'd1;
    assign w_a2 = w_a0 + 5'd2;
    assign w_a3 = w_a0 + 5'd3;
    always_ff @(posedge clk_i) begin
      if (start_i && r_exmem_mem_write) begin
        memory[w_a0] <= r_exmem_sdata[7:0];
        memory[w_a1] <= r_exmem_sdata[15:8];
        memory[w_a2] <= r_exmem_sdata[23:16];
        memory[w_a3] <= r_exmem_sdata[31:24];
      end
    end
    assign w_ld_data = {memory[w_a3], memory[w_a2], memory[w_a1], memory[w_a0]};
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_memwb_reg_write  <= 1'b0;
      r_memwb_mem_to_reg <= 1'b0;
      r_memwb_alu        <= '0;
      r_memwb_ldata      <= '0;
      r_memwb_wreg       <= '0;
    end else begin
      r_memwb_reg_write  <= r_exmem_reg_write;
      r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
      r_memwb_alu        <= r_exmem_alu;
      r_memwb_ldata      <= w_ld_data;
      r_memwb_wreg       <= r_exmem_wreg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_cpu.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pipeline_cpu
//  Purpose   : Self-checking bench for pipeline_cpu. An instruction-level
//              interpreter predicts the ordered register writes and final
//              architectural state; a monitor checks every write-back
//              against it, and directed literals pin PC, stall and flush.
//  Config    : PIPE_MUL_EN - mul expectation follows the same macro.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_pipeline_cpu;

  logic clk_i = 1'b0;
  logic start_i;

  always #5 clk_i = ~clk_i;

  pipeline_cpu dut (
    .clk_i   (clk_i),
    .start_i (start_i)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
  } wb_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wb_t         exp_q[$];
  wb_t         mon_e;
  logic [31:0] pc_trace[$];
  logic [31:0] prog  [0:255];
  logic [31:0] m_reg [0:31];
  logic [7:0]  m_mem [0:31];
  bit          mon_en = 1'b0;
  int          stall_cnt, flush_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic model_run();
    logic [31:0] pc, ins, a, b, imm, res, addr;
    logic [4:0]  rs, rt, rd, dst, b0, b1, b2, b3;
    logic [5:0]  op, fn;
    bit          wr;
    wb_t         t;
    pc = 32'd0;
    for (int s = 0; s < 32; s++) begin
      ins = prog[pc[9:2]];
      op  = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      a   = (rs == 5'd0) ? 32'd0 : m_reg[rs];
      b   = (rt == 5'd0) ? 32'd0 : m_reg[rt];
      imm = {{16{ins[15]}}, ins[15:0]};
      addr = a + imm;
      b0 = addr[4:0]; b1 = b0 + 5'd1; b2 = b0 + 5'd2; b3 = b0 + 5'd3;
      wr = 1'b0; dst = rt; res = 32'd0;
      pc = pc + 32'd4;
      case (op)
        6'h00: begin
          dst = rd; wr = 1'b1;
          case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
`ifdef PIPE_MUL_EN
            6'h18: res = a * b;
`endif
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; res = addr; end
        6'h23: begin wr = 1'b1; res = {m_mem[b3], m_mem[b2], m_mem[b1], m_mem[b0]}; end
        6'h2B: begin
          m_mem[b0] = b[7:0];   m_mem[b1] = b[15:8];
          m_mem[b2] = b[23:16]; m_mem[b3] = b[31:24];
        end
        6'h04: if (a == b) pc = pc + {imm[29:0], 2'b00};
        6'h02: pc = {pc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      if (wr && dst != 5'd0) begin
        m_reg[dst] = res;
        t.r = dst; t.v = res;
        exp_q.push_back(t);
      end
    end
  endtask

  // Every DUT write-back must be the next write the interpreter predicted.
  always @(negedge clk_i) begin
    if (mon_en) begin
      pc_trace.push_back(dut.PC.pc_o);
      if (dut.Hazard_Detection_Unit.ID_Flush_lwstall_o) stall_cnt++;
      if (dut.andGate_o) flush_cnt++;
      if (dut.w_wb_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_extra: got write $%0d=0x%08h required none", dut.r_memwb_wreg, dut.w_wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_reg", {27'd0, dut.r_memwb_wreg}, {27'd0, mon_e.r});
          check("wb_data", dut.w_wb_data, mon_e.v);
        end
      end
    end
  end

  task automatic clear_state();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_mem[i] = 8'd0; end
    m_reg[8] = 32'd5;
  endtask

  // Reset two edges, preload, predict, then run ncyc cycles under the monitor.
  task automatic run_test(input string tag, input int ncyc);
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = prog[i];
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i]  = m_reg[i];
      dut.Data_Memory.memory[i] = m_mem[i];
    end
    exp_q.delete(); pc_trace.delete();
    stall_cnt = 0; flush_cnt = 0;
    model_run();
    check({tag, "_reset_pc"}, dut.PC.pc_o, 32'd0);
    check({tag, "_reset_stall"}, {31'd0, dut.Hazard_Detection_Unit.ID_Flush_lwstall_o}, 32'd0);
    check({tag, "_reset_flush"}, {31'd0, dut.andGate_o}, 32'd0);
    start_i = 1'b1;
    @(posedge clk_i);
    mon_en = 1'b1;
    repeat (ncyc) @(posedge clk_i);
    mon_en = 1'b0;
    @(negedge clk_i);
    check({tag, "_wb_pending"}, exp_q.size(), 32'd0);
    for (int i = 1; i < 32; i++) check({tag, "_reg"}, dut.Registers.register[i], m_reg[i]);
    for (int i = 0; i < 32; i++) check({tag, "_mem"}, {24'd0, dut.Data_Memory.memory[i]}, {24'd0, m_mem[i]});
  endtask

  initial begin
    start_i = 1'b0;

    // Reset and free-running fetch over empty memory
    clear_state();
    run_test("reset", 3);
    check("reset_pc1", pc_trace[0], 32'd4);
    check("reset_pc2", pc_trace[1], 32'd8);
    check("reset_pc3", pc_trace[2], 32'd12);
    check("reset_nostall", stall_cnt, 0);
    check("reset_noflush", flush_cnt, 0);

    // Back-to-back ALU dependencies, all forwarded
    clear_state();
    prog[0] = enc_i(6'h08, 0, 9, 16'd3);
    prog[1] = enc_r(9, 8, 10, 6'h20);
    prog[2] = enc_r(10, 9, 11, 6'h22);
    run_test("alu", 10);
    check("alu_r9", dut.Registers.register[9], 32'd3);
    check("alu_r10", dut.Registers.register[10], 32'd8);
    check("alu_r11", dut.Registers.register[11], 32'd5);
    check("alu_nostall", stall_cnt, 0);

    // Load-use: one bubble, PC held for one cycle
    clear_state();
    m_mem[0] = 8'd5;
    prog[0] = enc_i(6'h23, 0, 9, 16'd0);
    prog[1] = enc_r(9, 9, 10, 6'h20);
    run_test("lduse", 10);
    check("lduse_r10", dut.Registers.register[10], 32'd10);
    check("lduse_stalls", stall_cnt, 1);
    check("lduse_pc1", pc_trace[1], 32'd8);
    check("lduse_pc_hold", pc_trace[2], 32'd8);
    check("lduse_pc3", pc_trace[3], 32'd12);

    // Taken branch skips the slot at PC 4
    clear_state();
    prog[0] = enc_i(6'h04, 8, 8, 16'd1);
    prog[1] = enc_i(6'h08, 0, 12, 16'd7);
    prog[2] = enc_i(6'h08, 0, 13, 16'd9);
    run_test("beq", 10);
    check("beq_r12", dut.Registers.register[12], 32'd0);
    check("beq_r13", dut.Registers.register[13], 32'd9);
    check("beq_flush", flush_cnt, 1);
    check("beq_pc1", pc_trace[0], 32'd4);
    check("beq_pc2", pc_trace[1], 32'd8);

    // Store then load, followed by a not-taken beq
    clear_state();
    prog[0] = enc_i(6'h2B, 0, 8, 16'd4);
    prog[1] = enc_i(6'h23, 0, 14, 16'd4);
    prog[2] = enc_i(6'h04, 8, 0, 16'd1);
    run_test("stld", 10);
    check("stld_b4", {24'd0, dut.Data_Memory.memory[4]}, 32'h05);
    check("stld_b5", {24'd0, dut.Data_Memory.memory[5]}, 32'h00);
    check("stld_b6", {24'd0, dut.Data_Memory.memory[6]}, 32'h00);
    check("stld_b7", {24'd0, dut.Data_Memory.memory[7]}, 32'h00);
    check("stld_r14", dut.Registers.register[14], 32'd5);
    check("stld_noflush", flush_cnt, 0);

    // Multiply (present only when the option is built in)
    clear_state();
    prog[0] = enc_r(8, 8, 15, 6'h18);
    run_test("mul", 10);
`ifdef PIPE_MUL_EN
    check("mul_r15", dut.Registers.register[15], 32'd25);
`else
    check("mul_r15", dut.Registers.register[15], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_cpu.md
# pipeline_cpu

Five-stage in-order pipelined processor (IF, ID, EX, MEM, WB) executing a MIPS-style 32-bit integer subset. It is the top of the processor design: it contains the PC, instruction memory, register file, data memory, forwarding, load-use stall logic and branch flush. Its only inputs are the clock and start; the bench preloads the memories and observes state hierarchically.

## Interface
- No parameters. Sizes are fixed: instruction memory 256×32-bit words, data memory 32×8-bit bytes, 32×32-bit registers.
- clk_i  input  1  clock; everything is rising-edge.
- start_i  input  1  reset, synchronous and active-low. Low means reset is held; high means run.
- Required instance/array names, for bench preload and observation:
  - Instruction_Memory.memory[0:255] (32-bit)
  - Data_Memory.memory[0:31] (8-bit)
  - Registers.register[0:31] (32-bit)
  - PC.pc_o

## Operation
- Instruction encoding is standard MIPS.
  - R-type, opcode 0: add (funct 0x20), sub (0x22), and (0x24), or (0x25), mul (0x18).
  - I-type: addi (0x08), lw (0x23), sw (0x2B), beq (0x04).
  - J-type: j (0x02).
- Any other opcode or funct executes as a NOP. Writes to register 0 are discarded; register 0 always reads 0.
- Instruction fetch uses word index pc[9:2]. Data memory is byte-addressed, little-endian; lw/sw move bytes addr..addr+3, and address bits [4:0] are used.
- addi, lw and sw sign-extend the 16-bit immediate. All arithmetic is 32-bit and wraps. mul keeps the low 32 bits of the product.
- beq and j resolve in ID.
  - beq compares the forwarded register values. If taken, next PC = PC_ID + 4 + (sext(imm) << 2).
  - j: next PC = {PC_ID+4[31:28], target, 2'b00}.
  - A taken branch or a jump flushes IF/ID (inserts a NOP) once: 1-cycle penalty. The flush flag is andGate_o.
- Forwarding into EX operands: EX/MEM has priority over MEM/WB, and the source register must be non-zero.
- Forwarding into ID branch comparison comes from EX/MEM.
- Load-use hazard: when an lw in EX has rt matching rs or rt of the instruction in ID:
  - hold PC and IF/ID;
  - zero the ID/EX control bits;
  - this is a 1-cycle stall. The stall flag is Hazard_Detection_Unit.ID_Flush_lwstall_o.
- A beq in ID whose operand depends on the instruction in EX also stalls 1 cycle.
- The register file writes on the rising edge and bypasses internally: a read of the register being written returns the new value.

## Timing
- Reset (start_i low at a rising edge):
  - PC = 0;
  - all pipeline registers cleared, with control bits 0 (NOP);
  - stall and flush flags = 0.
  - Memories and the register file are not reset.
- Run:
  - PC advances by 4 per cycle unless stalled or redirected.
  - An instruction fetched in cycle n writes back at the rising edge ending cycle n+4.
  - A store writes data memory at the rising edge ending its MEM cycle (n+3).
- Simultaneous stall and taken branch: the stall wins, and the branch re-evaluates next cycle.
- Reset has priority over every other update.
- Deassertion mid-run restarts from PC 0 with the existing memory and register contents.

## Configuration
- PIPE_MUL_EN defined: mul is decoded, and EX contains a 32×32 multiplier giving the low 32 bits.
- PIPE_MUL_EN undefined: funct 0x18 executes as a NOP with no register write, and no multiplier is synthesized.

## Structure
- Shared package cpu_pkg holds:
  - opcode and funct constants;
  - the ALU-control enum (ADD, SUB, AND, OR, MUL);
  - widths (XLEN = 32, IMEM_WORDS = 256, DMEM_BYTES = 32).
- One natural sub-module: forwarding_unit, which is combinational and produces the EX operand select and ID branch-forward selects.
- The remaining units are inline in the top level.

## Test plan
- Reset:
  - Hold start_i = 0 for 2 edges, then 1, with empty memory.
  - Required: PC.pc_o = 0, then 4, 8, 12; no register changes; stall = flush = 0.
- Back-to-back ALU dependency:
  - Initial register[8] = 5. Program: addi $9,$0,3; add $10,$9,$8; sub $11,$10,$9.
  - Required: $9 = 3, $10 = 8, $11 = 5, with no stall cycles.
- Load-use:
  - Initial memory[0] = 5. Program: lw $9,0($0); add $10,$9,$9.
  - Required: $10 = 10, exactly 1 stall, PC held one cycle.
- Taken branch:
  - Program: beq $8,$8,+1 at PC 0; addi $12,$0,7 at PC 4; addi $13,$0,9 at PC 8.
  - Required: $12 = 0, $13 = 9, flush = 1, PC goes 4 → 8.
- Store/load:
  - Program: sw $8,4($0); lw $14,4($0).
  - Required: bytes 4..7 = 05,00,00,00 and $14 = 5. A not-taken beq $8,$0 gives flush = 0.
- Multiply:
  - Program: mul $15,$8,$8.
  - Required: $15 = 25 with PIPE_MUL_EN defined; $15 unchanged (0) without it.
